gt_lane_sequencer: RTL
======================

// Module: gt_lane_sequencer
//
// PURPOSE
// Parametrised power-good, reset and link-bringup sequencer for one multi-lane serial transceiver block.
// Holds the transceiver reset, waits for every lane's power-good, qualifies it over a settling window,
// then asserts the TX/RX user-clock-active flags.
// Runs a link watchdog over the PCS link_up flags and retries the whole bringup a bounded number of times.
// After the final retry it latches a fault. Sits on the free-running reset clock between the transceiver wizard and the PCS lanes.
//
// PARAMETERS
// LANES          4           number of transceiver lanes (1..16)
// LANE_MASK      {LANES{1}}  bit set = lane counted by link watchdog; pwrgood always checks all lanes
// RESET_CYCLES   16          cycles gty_reset held high per bringup attempt (>=1)
// SETTLE_CYCLES  65535       consecutive all-pwrgood cycles required before clocks declared stable (>=1)
// LINK_TIMEOUT   125000000   cycles in RUN without all masked links up before a retry (>=1)
// MAX_RETRIES    3           retries allowed before FAULT; retry_count width = $clog2(MAX_RETRIES+1)
//
// PORTS
// clk              in   1      free-running reset/sequencing clock
// rst_n            in   1      asynchronous reset, active low
// reset_req        in   1      sync pulse: restart bringup from RESET and clear retries/fault
// pwrgood          in   LANES  per-lane transceiver power-good (asynchronous; 2-FF synchronised inside)
// link_up          in   LANES  per-lane PCS link_up (foreign clock domains; 2-FF synchronised inside)
// gty_reset        out  1      reset-all to transceiver wizard, active high
// tx_clock_stable  out  1      TX user clock active flag to wizard
// rx_clock_stable  out  1      RX user clock active flag to wizard
// all_links_up     out  1      state==RUN and every masked lane's synchronised link_up high
// fault            out  1      bringup abandoned; sticky until reset_req or rst_n
// retry_count      out  RW     retries consumed in the current bringup
// state            out  3      RESET=0 WAIT_PGOOD=1 SETTLE=2 RUN=3 FAULT=4
//
// BEHAVIOUR
// - rst_n low (async): state=RESET, gty_reset=1, tx/rx_clock_stable=0, fault=0, retry_count=0, all counters 0, sync flops 0.
// - All outputs registered. pg = &pwrgood_sync; lu = &(link_up_sync | ~LANE_MASK). Sync adds 2 cycles input latency.
// - Event priority each cycle: reset_req > loss of pg > watchdog timeout > normal transition.
// - RESET: gty_reset=1, clocks stable=0. Count RESET_CYCLES cycles, then go to WAIT_PGOOD; gty_reset=0 from that cycle.
// - WAIT_PGOOD: when pg=1, go to SETTLE with settle counter=0.
// - SETTLE: counter +1 per cycle while pg=1.
//   - pg=0: go to WAIT_PGOOD, counter cleared.
//   - Counter reaching SETTLE_CYCLES-1: go to RUN; tx/rx_clock_stable=1 on the same edge.
// - RUN: watchdog +1 per cycle while lu=0; cleared while lu=1.
//   - lu=1 also clears retry_count.
//   - pg=0: go to WAIT_PGOOD; clocks stable=0 next cycle; no retry consumed; watchdog cleared.
//   - Watchdog reaching LINK_TIMEOUT-1:
//     - retry_count==MAX_RETRIES: go to FAULT.
//     - otherwise retry_count+1 and go to RESET.
// - FAULT: gty_reset=1, clocks stable=0, fault=1. Only exits on reset_req or rst_n.
// - reset_req in any state: go to RESET, retry_count=0, fault=0, all counters cleared. reset_req during RESET restarts the RESET count.
// - Counters saturate-safe: width sized to parameter; no wrap before the terminal compare.
// - all_links_up forced 0 outside RUN, even if the links report up.
//
// TESTING (LANES=4, RESET_CYCLES=4, SETTLE_CYCLES=8, LINK_TIMEOUT=32, MAX_RETRIES=2)
// 1. Release rst_n with pwrgood=4'hF, link_up=0.
//    -> gty_reset high for 4 cycles after release; state 0->1->2.
//    -> clock_stable rises 8 cycles after entering SETTLE (plus 2-cycle sync).
// 2. Drop pwrgood[2] for 1 cycle at settle count 5.
//    -> state returns to WAIT_PGOOD, then SETTLE; clock_stable delayed by a full 8-cycle window.
// 3. Keep link_up=0 forever.
//    -> after each 32-cycle RUN, retry_count 1 then 2 with gty_reset re-pulsed.
//    -> third timeout gives state=4, fault=1, gty_reset=1, clock_stable=0.
// 4. Pulse reset_req in FAULT.
//    -> next cycle state=0, fault=0, retry_count=0; full bringup repeats.
// 5. In RUN with retry_count=1, drop pwrgood[0].
//    -> clock_stable=0 next cycle after sync, state=1, retry_count stays 1.
//    -> then set link_up=F in RUN: all_links_up=1, retry_count=0.
// 6. LANE_MASK=4'b0111, link_up=4'b0111 in RUN.
//    -> all_links_up=1, watchdog never fires over 100 cycles.

Source files
------------

// File: rtl/gt_lane_sequencer.sv
// Power-good / reset / link-bringup sequencer for one multi-lane transceiver block.
// Holds the wizard in reset, qualifies power-good, then watches PCS link_up with bounded retries.
module gt_lane_sequencer #(
  parameter int unsigned      LANES         = 4,
  parameter logic [LANES-1:0] LANE_MASK     = {LANES{1'b1}},
  parameter int unsigned      RESET_CYCLES  = 16,
  parameter int unsigned      SETTLE_CYCLES = 65535,
  parameter int unsigned      LINK_TIMEOUT  = 125000000,
  parameter int unsigned      MAX_RETRIES   = 3,
  localparam int unsigned     RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             reset_req,
  input  logic [LANES-1:0] pwrgood,
  input  logic [LANES-1:0] link_up,
  output logic             gty_reset,
  output logic             tx_clock_stable,
  output logic             rx_clock_stable,
  output logic             all_links_up,
  output logic             fault,
  output logic [RW-1:0]    retry_count,
  output logic [2:0]       state
);

  localparam int unsigned RCW = $clog2(RESET_CYCLES + 1);
  localparam int unsigned SCW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned WCW = $clog2(LINK_TIMEOUT + 1);
  localparam logic [RCW-1:0] RST_LAST = RCW'(RESET_CYCLES - 1);
  localparam logic [SCW-1:0] SET_LAST = SCW'(SETTLE_CYCLES - 1);
  localparam logic [WCW-1:0] WD_LAST  = WCW'(LINK_TIMEOUT - 1);
  localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET      = 3'd0,
    S_WAIT_PGOOD = 3'd1,
    S_SETTLE     = 3'd2,
    S_RUN        = 3'd3,
    S_FAULT      = 3'd4
  } state_t;

  state_t           st_q, st_d;
  logic [LANES-1:0] pwrgood_p0, pwrgood_p1;
  logic [LANES-1:0] link_up_p0, link_up_p1;
  logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
  logic [SCW-1:0]   set_cnt_q, set_cnt_d;
  logic [WCW-1:0]   wd_cnt_q, wd_cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             pg, lu;
  logic             gty_reset_d, clock_stable_d, all_links_up_d, fault_d;

  // Stage boundary: two-flop synchronisers for the asynchronous lane status inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwrgood_p0 <= '0;
      pwrgood_p1 <= '0;
      link_up_p0 <= '0;
      link_up_p1 <= '0;
    end else begin
      pwrgood_p0 <= pwrgood;
      pwrgood_p1 <= pwrgood_p0;
      link_up_p0 <= link_up;
      link_up_p1 <= link_up_p0;
    end
  end

  assign pg = &pwrgood_p1;
  assign lu = &(link_up_p1 | ~LANE_MASK);

  always_comb begin
    st_d      = st_q;
    rst_cnt_d = rst_cnt_q;
    set_cnt_d = set_cnt_q;
    wd_cnt_d  = wd_cnt_q;
    retry_d   = retry_q;
    if (reset_req) begin
      st_d      = S_RESET;
      rst_cnt_d = '0;
      set_cnt_d = '0;
      wd_cnt_d  = '0;
      retry_d   = '0;
    end else begin
      case (st_q)
        S_RESET: begin
          if (rst_cnt_q == RST_LAST) begin
            st_d      = S_WAIT_PGOOD;
            rst_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + RCW'(1);
          end
        end
        S_WAIT_PGOOD: begin
          if (pg) begin
            st_d      = S_SETTLE;
            set_cnt_d = '0;
          end
        end
        S_SETTLE: begin
          if (!pg) begin
            st_d      = S_WAIT_PGOOD;
            set_cnt_d = '0;
          end else if (set_cnt_q == SET_LAST) begin
            st_d      = S_RUN;
            set_cnt_d = '0;
            wd_cnt_d  = '0;
          end else begin
            set_cnt_d = set_cnt_q + SCW'(1);
          end
        end
        S_RUN: begin
          // Power loss outranks the watchdog and does not consume a retry
          if (!pg) begin
            st_d     = S_WAIT_PGOOD;
            wd_cnt_d = '0;
          end else if (lu) begin
            wd_cnt_d = '0;
            retry_d  = '0;
          end else if (wd_cnt_q == WD_LAST) begin
            wd_cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              st_d = S_FAULT;
            end else begin
              retry_d   = retry_q + RW'(1);
              st_d      = S_RESET;
              rst_cnt_d = '0;
            end
          end else begin
            wd_cnt_d = wd_cnt_q + WCW'(1);
          end
        end
        S_FAULT: st_d = S_FAULT;
        default: st_d = S_RESET;
      endcase
    end
    gty_reset_d    = (st_d == S_RESET) || (st_d == S_FAULT);
    clock_stable_d = (st_d == S_RUN);
    fault_d        = (st_d == S_FAULT);
    all_links_up_d = (st_d == S_RUN) && lu;
  end

  // Stage boundary: state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q            <= S_RESET;
      rst_cnt_q       <= '0;
      set_cnt_q       <= '0;
      wd_cnt_q        <= '0;
      retry_q         <= '0;
      gty_reset       <= 1'b1;
      tx_clock_stable <= 1'b0;
      rx_clock_stable <= 1'b0;
      fault           <= 1'b0;
      all_links_up    <= 1'b0;
    end else begin
      st_q            <= st_d;
      rst_cnt_q       <= rst_cnt_d;
      set_cnt_q       <= set_cnt_d;
      wd_cnt_q        <= wd_cnt_d;
      retry_q         <= retry_d;
      gty_reset       <= gty_reset_d;
      tx_clock_stable <= clock_stable_d;
      rx_clock_stable <= clock_stable_d;
      fault           <= fault_d;
      all_links_up    <= all_links_up_d;
    end
  end

  assign retry_count = retry_q;
  assign state       = st_q;

endmodule
